muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have one clock and synchronous active-low reset: clk (rising edge); rst_n, active-low, sampled only on rising clk.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request from execute stage, qualified by op
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 reserved
- a  in  32  rs operand (execute-stage A value)
- b  in  32  rt operand (execute-stage B value)
- flush  in  1  abort any in-flight operation
- busy  out  1  iterative operation in progress; pipeline stall request
- done  out  1  one-cycle pulse: HI/LO updated by MULT/DIV
- hi  out  32  HI register
- lo  out  32  LO register

Function
REQ-003 SHALL implement FSM with states IDLE, RUN, FIX; reset state IDLE.
REQ-004 In IDLE, start with op 0-3 SHALL latch a, b and op, load iteration counter with 31, and enter RUN.
REQ-005 In IDLE, start with op 4 (MTHI) or op 5 (MTLO) SHALL write a into hi or lo at that edge, stay IDLE, and leave busy and done low.
REQ-006 In IDLE, start with op 6-7 SHALL be ignored.
REQ-007 RUN SHALL perform one radix-2 step per cycle:
- multiply: shift-add on operand magnitudes
- divide: restoring step on operand magnitudes
REQ-008 RUN SHALL decrement the counter each cycle and enter FIX in the cycle after the step taken with counter==0 (32 steps total).
REQ-009 FIX SHALL apply the sign fix-up, write hi and lo, pulse done high for that cycle, and return to IDLE.
REQ-010 busy SHALL be high in RUN and in FIX.
REQ-011 Latency SHALL be fixed at 33 cycles:
- accept edge E0
- busy high for cycles E0+1 .. E0+33
- done and new hi/lo visible in cycle E0+33
- busy low from E0+34
REQ-012 MULT/MULTU SHALL produce the 64-bit product: {hi, lo} = a*b, signed for MULT and unsigned for MULTU.
REQ-013 DIV/DIVU SHALL set lo = quotient truncated toward zero and hi = remainder with the sign of the dividend.
REQ-014 Divide by zero SHALL complete in 33 cycles with lo = 32'hFFFFFFFF and hi = a (signed and unsigned).
REQ-015 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL produce lo = 32'h80000000 and hi = 0.
REQ-016 start while busy SHALL be ignored. The requester holds start until busy is low.
REQ-017 flush in any state SHALL force IDLE on the same edge:
- hi and lo unchanged
- done not asserted
- a flush coincident with start in IDLE discards the start.
REQ-018 hi and lo SHALL change only via REQ-005, REQ-009 or reset.
REQ-019 Operands SHALL be sampled only at accept. Changes on a and b during RUN SHALL have no effect.

Reset
REQ-020 When rst_n is low at a rising edge, the block SHALL set:
- state IDLE, counter 0
- hi = 0, lo = 0
- busy = 0, done = 0
REQ-021 Reset SHALL take priority over flush and start, including mid-RUN and during FIX; no done pulse follows.

Structure
REQ-022 A shared package SHALL hold:
- op encoding enum
- FSM state enum
- constant MD_ITER = 32
REQ-023 The datapath SHALL be one sub-module, muldiv_datapath, holding:
- magnitude/sign capture
- 64-bit partial-product and remainder/quotient registers
- step logic
- sign fix-up
The FSM, counter and HI/LO stay in muldiv_unit.

Verification
REQ-024 MULTU a=7, b=6 -> busy high 33 cycles; done at E0+33 with hi=0, lo=42.
REQ-025 MULT a=32'hFFFFFFFF, b=32'hFFFFFFFF -> hi=0, lo=1. MULT a=32'h80000000, b=2 -> hi=32'hFFFFFFFF, lo=0.
REQ-026 DIV a=-7, b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. DIVU a=7, b=0 -> lo=32'hFFFFFFFF, hi=7.
REQ-027 MTHI a=32'h1234 then MFHI-style read of hi -> hi=32'h1234 on the next cycle, busy never high. A start issued while busy is ignored.
REQ-028 DIVU started, flush at E0+10 -> busy low from E0+11, no done, hi/lo keep prior values. The same test with rst_n low at E0+10 -> hi=lo=0.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Contents: op encoding, FSM state encoding, iteration count and counter width.
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    OpMult  = 3'd0,
    OpMultu = 3'd1,
    OpDiv   = 3'd2,
    OpDivu  = 3'd3,
    OpMthi  = 3'd4,
    OpMtlo  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix
  } md_state_e;

  localparam int unsigned MD_ITER = 32;
  localparam int unsigned CntW    = $clog2(MD_ITER);

endpackage

// File: rtl/muldiv_datapath.sv
// Radix-2 multiply/divide datapath working on operand magnitudes.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   load_i         capture operands/signs for op_i (ops 0-3 only)
//   step_en_i      advance the 64-bit accumulator by one iteration
//   op_i, a_i, b_i operation and raw operands
//   res_hi_o/lo_o  sign-corrected result of the step being taken this cycle
module muldiv_datapath
  import muldiv_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        step_en_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] res_hi_o,
  output logic [31:0] res_lo_o
);

  logic [63:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] a_raw_q, a_raw_d;
  logic        div_q, div_d;
  logic        neg_q, neg_d;
  logic        rneg_q, rneg_d;
  logic        bzero_q, bzero_d;

  logic        is_signed, sa, sb;
  logic [31:0] ma, mb;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [33:0] div_diff;
  logic [63:0] div_next;
  logic [63:0] step_res;
  logic [63:0] prod;

  // Ops 0 and 2 are the signed variants.
  assign is_signed = ~op_i[0];
  assign sa        = is_signed & a_i[31];
  assign sb        = is_signed & b_i[31];
  assign ma        = sa ? (~a_i + 32'd1) : a_i;
  assign mb        = sb ? (~b_i + 32'd1) : b_i;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);
  assign mul_next = {mul_sum, acc_q[31:1]};

  // Restoring divide: acc = {remainder, dividend/quotient}, shifted left each step.
  assign div_diff = {1'b0, acc_q[63:31]} - {2'b00, mcand_q};
  assign div_next = div_diff[33] ? {acc_q[62:0], 1'b0}
                                 : {div_diff[31:0], acc_q[30:0], 1'b1};

  assign step_res = div_q ? div_next : mul_next;
  assign prod     = neg_q ? (~step_res + 64'd1) : step_res;

  always_comb begin
    res_hi_o = prod[63:32];
    res_lo_o = prod[31:0];
    if (div_q) begin
      if (bzero_q) begin
        res_hi_o = a_raw_q;
        res_lo_o = 32'hFFFF_FFFF;
      end else begin
        res_lo_o = neg_q  ? (~step_res[31:0] + 32'd1)  : step_res[31:0];
        res_hi_o = rneg_q ? (~step_res[63:32] + 32'd1) : step_res[63:32];
      end
    end
  end

  always_comb begin
    acc_d   = acc_q;
    mcand_d = mcand_q;
    a_raw_d = a_raw_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    bzero_d = bzero_q;
    if (load_i) begin
      // Same initial layout serves both: low half holds multiplier or dividend magnitude.
      acc_d   = {32'd0, ma};
      mcand_d = mb;
      a_raw_d = a_i;
      div_d   = op_i[1];
      neg_d   = sa ^ sb;
      rneg_d  = sa;
      bzero_d = (b_i == 32'd0);
    end else if (step_en_i) begin
      acc_d = step_res;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q   <= '0;
      mcand_q <= '0;
      a_raw_q <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      bzero_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      a_raw_q <= a_raw_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      bzero_q <= bzero_d;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// MIPS-style HI/LO multiply/divide unit with fixed 33-cycle latency.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   start, op    request and operation (MULT/MULTU/DIV/DIVU/MTHI/MTLO)
//   a, b         rs/rt operands, sampled only on accept
//   flush        abort in-flight operation, discard coincident start
//   busy         high while RUN/FIX (stall request)
//   done         one-cycle pulse when HI/LO are updated by an iterative op
//   hi, lo       architectural HI/LO registers
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic            load, step_en;
  logic [31:0]     res_hi, res_lo;

  muldiv_datapath u_datapath (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .step_en_i (step_en),
    .op_i      (op),
    .a_i       (a),
    .b_i       (b),
    .res_hi_o  (res_hi),
    .res_lo_o  (res_lo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    load    = 1'b0;
    step_en = 1'b0;
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (!op[2]) begin
              load    = 1'b1;
              cnt_d   = CntW'(MD_ITER - 1);
              state_d = StRun;
            end else if (op == OpMthi) begin
              hi_d = a;
            end else if (op == OpMtlo) begin
              lo_d = a;
            end
          end
        end
        StRun: begin
          step_en = 1'b1;
          if (cnt_q == '0) begin
            // Final step: result is sign-fixed combinationally so HI/LO and done
            // become visible together in the FIX cycle.
            state_d = StFix;
            hi_d    = res_hi;
            lo_d    = res_lo;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        StFix:   state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;
  logic [63:0] sb[$];

  muldiv_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    longint sp;
    int     sq, sr;
    case (o)
      3'd0: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        return 64'(sp);
      end
      3'd1: return {32'd0, x} * {32'd0, y};
      3'd2: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sq = $signed(x) / $signed(y);
        sr = $signed(x) % $signed(y);
        return {sr, sq};
      end
      3'd3: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Issue one iterative op and follow it cycle by cycle until well past completion.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [63:0] exp, input bit poke);
    logic [63:0] got;
    op = o; a = x; b = y; start = 1'b1;
    sb.push_back(exp);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 36; i++) begin
      chk({tag, " busy"}, 32'(busy), 32'(i <= 33));
      chk({tag, " done"}, 32'(done), 32'(i == 33));
      if (done) begin
        chk({tag, " sb_depth"}, 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
          got = sb.pop_front();
          chk({tag, " hi"}, hi, got[63:32]);
          chk({tag, " lo"}, lo, got[31:0]);
        end
      end
      if (i == 3) begin
        a = $urandom;
        b = $urandom;
      end
      if (poke && i >= 5 && i <= 8) begin
        start = 1'b1;
        op    = 3'd0;
        a     = $urandom;
        b     = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    chk({tag, " leftover"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic single(input logic [2:0] o, input logic [31:0] x, input logic fl);
    op = o; a = x; start = 1'b1; flush = fl;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    rst_n = 1'b1;

    run_op("multu 7x6", 3'd1, 32'd7, 32'd6, 64'd42, 1'b0);
    run_op("mult -1x-1", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 1'b0);
    run_op("mult min x2", 3'd0, 32'h8000_0000, 32'd2, {32'hFFFF_FFFF, 32'd0}, 1'b0);
    run_op("div -7/2", 3'd2, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
    run_op("divu 7/0", 3'd3, 32'd7, 32'd0, {32'd7, 32'hFFFF_FFFF}, 1'b0);
    run_op("div -5/0", 3'd2, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 1'b0);
    run_op("div min/-1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 1'b0);
    run_op("div 7/-2", 3'd2, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 1'b0);
    run_op("start while busy", 3'd1, 32'h0001_0000, 32'h0001_0000, 64'h1_0000_0000, 1'b1);

    for (int k = 0; k < 8; k++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = (k == 5) ? 32'($urandom_range(1, 9)) : $urandom;
      run_op("random", ro, ra, rb, model(ro, ra, rb), 1'b0);
    end

    single(3'd4, 32'h1234, 1'b0);
    chk("mthi hi", hi, 32'h1234);
    chk("mthi busy", 32'(busy), 32'd0);
    chk("mthi done", 32'(done), 32'd0);
    single(3'd5, 32'h5678, 1'b0);
    chk("mtlo lo", lo, 32'h5678);
    chk("mtlo hi kept", hi, 32'h1234);
    chk("mtlo busy", 32'(busy), 32'd0);
    single(3'd6, 32'hDEAD_BEEF, 1'b0);
    chk("reserved hi", hi, 32'h1234);
    chk("reserved lo", lo, 32'h5678);
    chk("reserved busy", 32'(busy), 32'd0);
    single(3'd4, 32'h9999, 1'b1);
    chk("flushed mthi", hi, 32'h1234);
    single(3'd3, 32'd100, 1'b1);
    chk("flushed start busy", 32'(busy), 32'd0);

    // Flush mid-run: edge E0+10 aborts.
    op = 3'd3; a = 32'd100; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i < 10; i++) begin
      @(posedge clk); #1;
    end
    chk("pre-flush busy", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush busy", 32'(busy), 32'd0);
    for (int i = 0; i < 30; i++) begin
      chk("flush done", 32'(done), 32'd0);
      @(posedge clk); #1;
    end
    chk("flush hi", hi, 32'h1234);
    chk("flush lo", lo, 32'h5678);
    chk("flush busy idle", 32'(busy), 32'd0);

    // Reset mid-run: edge E0+10 clears everything.
    op = 3'd3; a = 32'd100; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i < 10; i++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);
    for (int i = 0; i < 30; i++) begin
      chk("rst done", 32'(done), 32'd0);
      @(posedge clk); #1;
    end
    chk("rst busy idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
